// File: rtl/sap_ram_pkg.sv
// Shared types and helpers for the SAP-1 synchronous program/data RAM.
//   state_e    : controller states (CLEAR sequencer, READY for accesses)
//   RUN / PROG : values of run_not_prog selecting the access path
//   sram_depth : number of words addressed by an ADDR_WIDTH-bit address
package sap_ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic RUN  = 1'b1;
    localparam logic PROG = 1'b0;

    function automatic int unsigned sram_depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

endpackage

// File: rtl/sap_ram_array.sv
// Storage for the SAP-1 RAM: one synchronous write port, one registered read port.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i : write port, word written on the rising edge
//   re_i/raddr_i      : read port enable/address
//   rdata_o           : registered read word, holds when re_i is low
// The storage itself has no reset; the controller clears it after every reset.
module sap_ram_array
    import sap_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = sram_depth(ADDR_WIDTH);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port, one-cycle latency
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sap_ram_ctrl.sv
// SAP-1 synchronous program/data RAM controller.
// After every reset a clear sequencer zeroes all words (busy=1), then the RAM
// serves either the CPU run-mode port (ce_bar/we_bar) or the program loader
// (auto-incrementing prog_ptr, prog_wrap pulse on wrap to 0).
//   clk, rst           : clock, synchronous active-high reset
//   run_not_prog       : 1 run mode, 0 program mode
//   ce_bar, we_bar, addr, wr_data : run-mode access
//   rd_data            : registered read data
//   prog_addr_load, prog_addr, prog_we, prog_data : loader controls
//   prog_ptr, prog_wrap: loader pointer and wrap pulse
//   busy               : clear in progress, all requests ignored
//   parity_err         : stored-parity mismatch on last run read
// Optional: define SAP_RAM_PARITY_EN to store an even-parity bit per word;
// otherwise parity_err is tied to 0.
module sap_ram_ctrl
    import sap_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_not_prog,
    input  logic                  ce_bar,
    input  logic                  we_bar,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  prog_addr_load,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic                  prog_we,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic [ADDR_WIDTH-1:0] prog_ptr,
    output logic                  prog_wrap,
    output logic                  busy,
    output logic                  parity_err
);

    localparam int unsigned SRAM_DEPTH = sram_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);
`ifdef SAP_RAM_PARITY_EN
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int unsigned WORD_WIDTH = DATA_WIDTH;
`endif

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0] prog_ptr_q, prog_ptr_d;
    logic                  prog_wrap_q, prog_wrap_d;
    logic                  busy_q, busy_d;

    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdat;
    logic [WORD_WIDTH-1:0] mem_wword;
    logic [WORD_WIDTH-1:0] mem_rword;
    logic [ADDR_WIDTH-1:0] prog_waddr;

    // State and loader registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            prog_ptr_q  <= '0;
            prog_wrap_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            prog_ptr_q  <= prog_ptr_d;
            prog_wrap_q <= prog_wrap_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, memory port muxing and loader pointer update
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        prog_ptr_d  = prog_ptr_q;
        prog_wrap_d = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = clr_cnt_q;
        mem_wdat    = '0;
        // A simultaneous load redirects the write to the freshly loaded address
        prog_waddr  = prog_addr_load ? prog_addr : prog_ptr_q;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                case (run_not_prog)
                    RUN: begin
                        if (!ce_bar) begin
                            if (we_bar) begin
                                mem_re = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_waddr = addr;
                                mem_wdat  = wr_data;
                            end
                        end
                    end
                    PROG: begin
                        if (prog_we) begin
                            mem_we      = 1'b1;
                            mem_waddr   = prog_waddr;
                            mem_wdat    = prog_data;
                            prog_ptr_d  = prog_waddr + ADDR_WIDTH'(1);
                            prog_wrap_d = (prog_waddr == LAST_ADDR);
                        end else if (prog_addr_load) begin
                            prog_ptr_d = prog_addr;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = CLEAR;
        endcase

        busy_d = (state_d == CLEAR);
    end

`ifdef SAP_RAM_PARITY_EN
    // Even parity: stored bit makes the whole word XOR to zero
    assign mem_wword  = {^mem_wdat, mem_wdat};
    assign parity_err = ^mem_rword;
`else
    assign mem_wword  = mem_wdat;
    assign parity_err = 1'b0;
`endif

    sap_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wword),
        .re_i    (mem_re),
        .raddr_i (addr),
        .rdata_o (mem_rword)
    );

    assign rd_data   = mem_rword[DATA_WIDTH-1:0];
    assign prog_ptr  = prog_ptr_q;
    assign prog_wrap = prog_wrap_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sap_ram_ctrl.sv
// Self-checking bench for sap_ram_ctrl: behavioural memory model compared on
// every falling edge, plus hand-computed expectations for directed scenarios.
module tb_sap_ram_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
`ifdef SAP_RAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          run_not_prog;
    logic          ce_bar;
    logic          we_bar;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          prog_addr_load;
    logic [AW-1:0] prog_addr;
    logic          prog_we;
    logic [DW-1:0] prog_data;
    logic [AW-1:0] prog_ptr;
    logic          prog_wrap;
    logic          busy;
    logic          parity_err;

    sap_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .run_not_prog   (run_not_prog),
        .ce_bar         (ce_bar),
        .we_bar         (we_bar),
        .addr           (addr),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .prog_addr_load (prog_addr_load),
        .prog_addr      (prog_addr),
        .prog_we        (prog_we),
        .prog_data      (prog_data),
        .prog_ptr       (prog_ptr),
        .prog_wrap      (prog_wrap),
        .busy           (busy),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents plus observable outputs
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_bad [DEPTH];
    int            m_clr_left;
    logic [DW-1:0] m_rd;
    int            m_ptr;
    bit            m_wrap;
    bit            m_perr;
    int            m_wa;

    always @(posedge clk) begin
        if (rst) begin
            m_clr_left = DEPTH;
            m_rd       = '0;
            m_ptr      = 0;
            m_wrap     = 1'b0;
            m_perr     = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_bad[i] = 1'b0;
            end
        end else if (m_clr_left > 0) begin
            m_clr_left = m_clr_left - 1;
            m_wrap     = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (run_not_prog) begin
                if (!ce_bar && we_bar) begin
                    m_rd   = m_mem[addr];
                    m_perr = PAR && m_bad[addr];
                end else if (!ce_bar) begin
                    m_mem[addr] = wr_data;
                    m_bad[addr] = 1'b0;
                end
            end else begin
                m_wa = prog_addr_load ? int'(prog_addr) : m_ptr;
                if (prog_we) begin
                    m_mem[m_wa] = prog_data;
                    m_bad[m_wa] = 1'b0;
                    m_wrap      = (m_wa == DEPTH - 1);
                    m_ptr       = (m_wa + 1) % DEPTH;
                end else if (prog_addr_load) begin
                    m_ptr = int'(prog_addr);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       32'(busy),       32'(m_clr_left != 0));
            chk("rd_data",    32'(rd_data),    32'(m_rd));
            chk("prog_ptr",   32'(prog_ptr),   32'(m_ptr));
            chk("prog_wrap",  32'(prog_wrap),  32'(m_wrap));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
        end
    end

    task automatic run_rd(input int a);
        run_not_prog = 1'b1;
        addr   = AW'(a);
        ce_bar = 1'b0;
        we_bar = 1'b1;
        @(negedge clk);
        ce_bar = 1'b1;
    endtask

    task automatic run_wr(input int a, input logic [DW-1:0] d);
        run_not_prog = 1'b1;
        addr    = AW'(a);
        wr_data = d;
        ce_bar  = 1'b0;
        we_bar  = 1'b0;
        @(negedge clk);
        ce_bar = 1'b1;
        we_bar = 1'b1;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run_not_prog = 1'b1; ce_bar = 1'b1; we_bar = 1'b1;
        addr = '0; wr_data = '0; prog_addr_load = 1'b0; prog_addr = '0;
        prog_we = 1'b0; prog_data = '0;

        // Two-cycle reset
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_prog_ptr", 32'(prog_ptr), 32'h0);
        chk("rst_parity", 32'(parity_err), 32'h0);
        rst = 1'b0;
        count_busy("clear_busy_cycles");
        for (int i = 0; i < DEPTH; i++) begin
            run_rd(i);
            chk("clear_read_zero", 32'(rd_data), 32'h0);
        end

        // Reset again, then restart mid-clear
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy("midclear_busy_cycles");

        // Run-mode read/write
        run_wr(3, 8'hA5);
        chk("wr_holds_rd", 32'(rd_data), 32'h0);
        run_wr(15, 8'h3C);
        run_rd(3);
        chk("read_a5", 32'(rd_data), 32'hA5);
        run_wr(5, 8'h77);
        chk("wr_no_through", 32'(rd_data), 32'hA5);
        addr = AW'(15);
        @(negedge clk);
        chk("ce_hold", 32'(rd_data), 32'hA5);
        run_rd(15);
        chk("read_3c", 32'(rd_data), 32'h3C);
        run_wr(9, 8'hC3);
        run_rd(9);
        chk("wr_then_rd", 32'(rd_data), 32'hC3);

        // Program load with wrap; run ports driven to a write but ignored
        run_not_prog = 1'b0;
        ce_bar = 1'b0; we_bar = 1'b0; addr = AW'(14); wr_data = 8'hFF;
        prog_addr = AW'(14); prog_addr_load = 1'b1;
        @(negedge clk);
        prog_addr_load = 1'b0;
        chk("load_ptr", 32'(prog_ptr), 32'd14);
        prog_we = 1'b1; prog_data = 8'h11;
        @(negedge clk);
        chk("wrap_w14", 32'(prog_wrap), 32'h0);
        prog_data = 8'h22;
        @(negedge clk);
        chk("wrap_w15", 32'(prog_wrap), 32'h1);
        chk("ptr_after_w15", 32'(prog_ptr), 32'h0);
        prog_data = 8'h33;
        @(negedge clk);
        chk("wrap_w0", 32'(prog_wrap), 32'h0);
        prog_we = 1'b0;
        ce_bar = 1'b1; we_bar = 1'b1;
        @(negedge clk);
        chk("ptr_end", 32'(prog_ptr), 32'h1);
        chk("rd_held_prog", 32'(rd_data), 32'hC3);
        run_rd(14);
        chk("mem14", 32'(rd_data), 32'h11);
        run_rd(15);
        chk("mem15", 32'(rd_data), 32'h22);
        run_rd(0);
        chk("mem0", 32'(rd_data), 32'h33);

        // Simultaneous load + write, then mode toggle
        run_not_prog = 1'b0;
        prog_addr = AW'(7); prog_addr_load = 1'b1; prog_we = 1'b1; prog_data = 8'h5A;
        @(negedge clk);
        prog_addr_load = 1'b0; prog_we = 1'b0;
        chk("lw_ptr", 32'(prog_ptr), 32'd8);
        run_not_prog = 1'b1; prog_we = 1'b1; prog_data = 8'hEE;
        @(negedge clk);
        run_not_prog = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        chk("toggle_ptr", 32'(prog_ptr), 32'd8);
        run_rd(7);
        chk("mem7", 32'(rd_data), 32'h5A);
        run_rd(8);
        chk("mem8_untouched", 32'(rd_data), 32'h0);

`ifdef SAP_RAM_PARITY_EN
        // Corrupt a stored data bit and check detection
        run_wr(2, 8'h01);
        dut.u_array.mem_q[2][0] = 1'b0;
        m_mem[2] = 8'h00;
        m_bad[2] = 1'b1;
        run_rd(2);
        chk("par_err_set", 32'(parity_err), 32'h1);
        chk("par_data", 32'(rd_data), 32'h00);
        @(negedge clk);
        chk("par_err_hold", 32'(parity_err), 32'h1);
        run_rd(3);
        chk("par_err_clr", 32'(parity_err), 32'h0);
        chk("par_clean_data", 32'(rd_data), 32'hA5);
`else
        run_rd(2);
        chk("no_parity", 32'(parity_err), 32'h0);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
